// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns one LW/SW/LL/SC into a registered dcache
// request, owns the LL/SC link register, a sticky halt and a REQ-cycle statistic.
module mem_access_ctrl #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              op_valid,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic              halt_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [WORD_W-1:0] result_out,
  output logic              halt_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [WORD_W-1:0] WORD_MASK = ~WORD_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              link_valid_q, link_valid_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              ll_q, ll_d;
  logic              sc_q, sc_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [WORD_W-1:0] word_addr_c;
  logic              sc_pass_c;

  // SC succeeds only if the link survives this cycle's snoop as well
  assign word_addr_c = addr_in & WORD_MASK;
  assign sc_pass_c   = link_valid_q && (word_addr_c == link_addr_q) &&
                       !(snoop_inv && ((snoop_addr & WORD_MASK) == link_addr_q));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    result_d     = result_q;
    link_addr_d  = link_addr_q;
    link_valid_d = link_valid_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    ll_d         = ll_q;
    sc_d         = sc_q;
    halt_d       = halt_q;
    stall_cnt_d  = stall_cnt_q;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (halt_in) begin
            halt_d   = 1'b1;
            mem_done = 1'b1;
            state_d  = S_HALTED;
          end else if (dREN_in || dWEN_in) begin
            addr_d    = word_addr_c;
            data_d    = store_in;
            ren_d     = dREN_in;
            wen_d     = dWEN_in;
            ll_d      = dREN_in && ll_in;
            sc_d      = 1'b0;
            mem_stall = 1'b1;
            state_d   = S_REQ;
          end else if (sc_in) begin
            // hold EX/MEM until DONE so the SC cannot be skipped
            mem_stall = 1'b1;
            if (sc_pass_c) begin
              addr_d  = word_addr_c;
              data_d  = store_in;
              ren_d   = 1'b0;
              wen_d   = 1'b1;
              ll_d    = 1'b0;
              sc_d    = 1'b1;
              state_d = S_REQ;
            end else begin
              result_d     = '0;
              link_valid_d = 1'b0;
              state_d      = S_DONE;
            end
          end else begin
            mem_done = 1'b1;
          end
        end
      end

      S_REQ: begin
        mem_stall = op_valid;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (dhit) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = S_DONE;
          if (ren_q) result_d = dmemload;
          if (ll_q) begin
            link_addr_d  = addr_q;
            link_valid_d = 1'b1;
          end
          if (wen_q && (addr_q == link_addr_q)) link_valid_d = 1'b0;
          if (sc_q) begin
            result_d     = WORD_W'(1);
            link_valid_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        mem_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        mem_done = 1'b1;
      end
    endcase

    // Snoop is checked against the post-update link so it beats a same-cycle LL
    if (snoop_inv && ((snoop_addr & WORD_MASK) == link_addr_d)) link_valid_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      result_q     <= '0;
      link_addr_q  <= '0;
      link_valid_q <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      ll_q         <= 1'b0;
      sc_q         <= 1'b0;
      halt_q       <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      result_q     <= result_d;
      link_addr_q  <= link_addr_d;
      link_valid_q <= link_valid_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      ll_q         <= ll_d;
      sc_q         <= sc_d;
      halt_q       <= halt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign dmemREN      = ren_q;
  assign dmemWEN      = wen_q;
  assign dmemaddr     = addr_q;
  assign dmemstore    = data_q;
  assign result_out   = result_q;
  assign halt_out     = halt_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops push expected completions,
// a negedge monitor pops and compares whenever mem_done is presented.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        op_valid, dREN_in, dWEN_in, ll_in, sc_in, halt_in;
  logic [31:0] addr_in, store_in;
  logic        dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dmemREN, dmemWEN, mem_stall, mem_done, halt_out;
  logic [31:0] dmemaddr, dmemstore, result_out, stall_cycles;

  logic        d4_ren, d4_wen, d4_stall, d4_done, d4_halt;
  logic [31:0] d4_addr, d4_store, d4_result;
  logic [3:0]  d4_stall_cycles;

  always #5 CLK = ~CLK;

  mem_access_ctrl dut (
    .CLK(CLK), .RST(RST), .op_valid(op_valid), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .ll_in(ll_in), .sc_in(sc_in), .halt_in(halt_in), .addr_in(addr_in), .store_in(store_in),
    .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .mem_done(mem_done), .result_out(result_out),
    .halt_out(halt_out), .stall_cycles(stall_cycles)
  );

  mem_access_ctrl #(.WORD_W(32), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .op_valid(op_valid), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .ll_in(ll_in), .sc_in(sc_in), .halt_in(halt_in), .addr_in(addr_in), .store_in(store_in),
    .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(d4_ren), .dmemWEN(d4_wen), .dmemaddr(d4_addr), .dmemstore(d4_store),
    .mem_stall(d4_stall), .mem_done(d4_done), .result_out(d4_result),
    .halt_out(d4_halt), .stall_cycles(d4_stall_cycles)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] cnt);
    exp_t e;
    e.res = res;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Completion monitor
  always @(negedge CLK) begin
    if (!RST && mem_done && !halt_out) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: mem_done with empty queue, result %h", result_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_result", result_out, mon_e.res);
        chk("sb_stall_cycles", stall_cycles, mon_e.cnt);
        chk("sb_no_stall_at_done", 32'(mem_stall), 32'd0);
      end
    end
  end

  task automatic clear_inputs();
    op_valid = 0; dREN_in = 0; dWEN_in = 0; ll_in = 0; sc_in = 0; halt_in = 0;
    addr_in = '0; store_in = '0; dhit = 0; snoop_inv = 0; snoop_addr = '0;
  endtask

  // Issue one op (entered just after a posedge) and act as the dcache until mem_done.
  task automatic run_op(input string nm, input logic ren, input logic wen, input logic ll,
                        input logic sc, input logic halt, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int lat,
                        input logic snp, input logic [31:0] snp_addr,
                        output int req_n, output int stall_n,
                        output logic [31:0] seen_addr, output logic [31:0] seen_store,
                        output logic seen_ren, output logic seen_wen);
    logic done;
    op_valid = 1; dREN_in = ren; dWEN_in = wen; ll_in = ll; sc_in = sc; halt_in = halt;
    addr_in = addr; store_in = data; snoop_inv = snp; snoop_addr = snp_addr;
    req_n = 0; stall_n = 0; done = 0;
    seen_addr = '0; seen_store = '0; seen_ren = 0; seen_wen = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (c == 1) snoop_inv = 0;
      stall_n += int'(mem_stall);
      seen_ren |= dmemREN;
      seen_wen |= dmemWEN;
      if (mem_done) begin
        done = 1;
        dhit = 0;
      end else if (dmemREN || dmemWEN) begin
        if (req_n == 0) begin
          seen_addr  = dmemaddr;
          seen_store = dmemstore;
        end
        req_n++;
        dmemload = rdata;
        dhit = (req_n == lat);
      end else begin
        dhit = 0;
      end
    end
    chk({nm, "_completed"}, 32'(done), 32'd1);
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  int          rq, st;
  logic [31:0] sa, ss;
  logic        sr, sw;
  logic        got_req;

  initial begin
    clear_inputs();
    dmemload = '0;
    RST = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    chk("rst_dmemaddr", dmemaddr, 32'd0);
    chk("rst_dmemstore", dmemstore, 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_halt", 32'(halt_out), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    @(posedge CLK); #1;
    RST = 0;

    // LW 0x100, dhit on 3rd request cycle
    push(32'hDEADBEEF, 32'd3);
    run_op("lw", 1, 0, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("lw_stall_len", 32'(st), 32'd4);
    chk("lw_req_len", 32'(rq), 32'd3);
    chk("lw_addr", sa, 32'h100);
    chk("lw_ren", 32'(sr), 32'd1);
    @(negedge CLK);
    chk("lw_done_one_cycle", 32'(mem_done), 32'd0);
    chk("lw_result_held", result_out, 32'hDEADBEEF);
    @(posedge CLK); #1;

    // SW to unaligned address
    push(32'hDEADBEEF, 32'd5);
    run_op("sw", 0, 1, 0, 0, 0, 32'h103, 32'h12345678, 32'h0, 2, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sw_addr_aligned", sa, 32'h100);
    chk("sw_store", ss, 32'h12345678);
    chk("sw_wen", 32'(sw), 32'd1);
    chk("sw_no_ren", 32'(sr), 32'd0);
    chk("sw_req_len", 32'(rq), 32'd2);

    // LL then SC pass, then second SC fails
    push(32'hCAFE0001, 32'd6);
    run_op("ll1", 1, 0, 1, 0, 0, 32'h200, 32'h0, 32'hCAFE0001, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    push(32'd1, 32'd7);
    run_op("sc_pass", 0, 0, 0, 1, 0, 32'h200, 32'd5, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sc_pass_wen", 32'(sw), 32'd1);
    chk("sc_pass_store", ss, 32'd5);
    chk("sc_pass_addr", sa, 32'h200);
    push(32'd0, 32'd7);
    run_op("sc_again", 0, 0, 0, 1, 0, 32'h200, 32'd5, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sc_again_no_wen", 32'(sw), 32'd0);

    // Snoop to a neighbouring word leaves the link intact
    push(32'h11, 32'd8);
    run_op("ll2", 1, 0, 1, 0, 0, 32'h200, 32'h0, 32'h11, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    snoop_inv = 1; snoop_addr = 32'h204;
    @(posedge CLK); #1;
    snoop_inv = 0;
    push(32'd1, 32'd9);
    run_op("sc_after_snoop204", 0, 0, 0, 1, 0, 32'h200, 32'd7, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sc_snoop204_wen", 32'(sw), 32'd1);

    // Snoop to the linked word in the SC's IDLE cycle kills it
    push(32'h22, 32'd10);
    run_op("ll3", 1, 0, 1, 0, 0, 32'h200, 32'h0, 32'h22, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    push(32'd0, 32'd10);
    run_op("sc_snooped", 0, 0, 0, 1, 0, 32'h200, 32'd7, 32'h0, 1, 1, 32'h200, rq, st, sa, ss, sr, sw);
    chk("sc_snooped_no_wen", 32'(sw), 32'd0);

    // Own SW to the linked word clears the link
    push(32'h33, 32'd11);
    run_op("ll4", 1, 0, 1, 0, 0, 32'h300, 32'h0, 32'h33, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    push(32'h33, 32'd12);
    run_op("sw_link", 0, 1, 0, 0, 0, 32'h302, 32'd9, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    push(32'd0, 32'd12);
    run_op("sc_after_sw", 0, 0, 0, 1, 0, 32'h300, 32'd1, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sc_after_sw_no_wen", 32'(sw), 32'd0);

    // Reset mid-REQ drops the request and the link
    push(32'h55, 32'd13);
    run_op("ll5", 1, 0, 1, 0, 0, 32'h500, 32'h0, 32'h55, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    op_valid = 1; dREN_in = 1; addr_in = 32'h600;
    got_req = 0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(negedge CLK);
      got_req = dmemREN;
    end
    chk("rst_mid_req_seen", 32'(got_req), 32'd1);
    RST = 1;
    clear_inputs();
    @(negedge CLK);
    chk("rst_mid_ren", 32'(dmemREN), 32'd0);
    chk("rst_mid_stall_cycles", stall_cycles, 32'd0);
    chk("rst_mid_result", result_out, 32'd0);
    chk("rst_mid_mem_stall", 32'(mem_stall), 32'd0);
    @(posedge CLK); #1;
    RST = 0;
    push(32'd0, 32'd0);
    run_op("sc_after_rst", 0, 0, 0, 1, 0, 32'h500, 32'd3, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("sc_after_rst_no_wen", 32'(sw), 32'd0);

    // 20 request cycles: 32-bit counter reads 20, 4-bit counter saturates at 15
    push(32'h77, 32'd20);
    run_op("lw_long", 1, 0, 0, 0, 0, 32'h700, 32'h0, 32'h77, 20, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("lw_long_stall_len", 32'(st), 32'd21);
    chk("sat_cnt4", 32'(d4_stall_cycles), 32'd15);

    // HALT is sticky and blocks later ops
    push(32'h77, 32'd20);
    run_op("halt", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    @(negedge CLK);
    chk("halt_out", 32'(halt_out), 32'd1);
    chk("halted_done", 32'(mem_done), 32'd1);
    @(posedge CLK); #1;
    run_op("lw_halted", 1, 0, 0, 0, 0, 32'h800, 32'h0, 32'h88, 1, 0, 32'h0, rq, st, sa, ss, sr, sw);
    chk("halted_no_ren", 32'(sr), 32'd0);
    chk("halted_no_stall", 32'(st), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("halt_sticky", 32'(halt_out), 32'd1);
    chk("halted_stall_cycles", stall_cycles, 32'd20);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller between the EX/MEM latch and the MEM/WB latch.
- Turns one decoded memory op (LW, SW, LL, SC) into a registered dcache request and waits for dhit.
- Produces load/SC result data for MEM/WB and a stall to the hazard unit.
- Owns the LL/SC link register and a sticky halt.

Parameters:
WORD_W, 32, data/address width
CNT_W, 32, width of stall-cycle statistic counter

Ports:
CLK  in  1  clock
RST  in  1  reset
op_valid  in  1  EX/MEM holds a valid instruction
dREN_in  in  1  load (LW or LL)
dWEN_in  in  1  store (SW)
ll_in  in  1  op is LL (with dREN_in)
sc_in  in  1  op is SC (dREN_in=dWEN_in=0)
halt_in  in  1  op is HALT
addr_in  in  WORD_W  effective address
store_in  in  WORD_W  store data
dhit  in  1  dcache access complete
dmemload  in  WORD_W  dcache read data
snoop_inv  in  1  coherence invalidate this cycle
snoop_addr  in  WORD_W  invalidated address
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  WORD_W  request address, bits [1:0] forced 00
dmemstore  out  WORD_W  store data
mem_stall  out  1  freeze upstream stages and hold EX/MEM
mem_done  out  1  op completes this cycle; MEM/WB may capture
result_out  out  WORD_W  load data or SC result
halt_out  out  1  sticky halt
stall_cycles  out  CNT_W  saturating count of REQ cycles

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- States: IDLE, REQ, DONE, HALTED.
- Reset, sampled at a CLK edge, overrides everything, including mid-REQ:
  - state goes to IDLE; link_valid=0, link_addr=0; latched addr/data=0; result register=0; stall_cycles=0.
  - Outputs after reset: dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, mem_done=0, result_out=0, halt_out=0.
  - mem_stall follows its combinational rule and is 0 with op_valid=0.
  - An outstanding dcache request is simply dropped.
- IDLE:
  - op_valid & halt_in: go HALTED.
  - op_valid & (dREN_in|dWEN_in): latch addr/data/type, go REQ.
  - op_valid & sc_in & link_valid & addr_in[31:2]==link_addr[31:2] & no matching snoop this cycle: latch as store, sc_ok=1, go REQ.
  - op_valid & sc_in otherwise: sc_ok=0, go DONE with no dcache request.
  - Non-memory op or op_valid=0: stay in IDLE; mem_done=1 when op_valid (zero latency).
- REQ:
  - dmemREN/dmemWEN driven only from registered state, never combinationally from inputs.
  - Held until dhit. On dhit: capture dmemload into result register (loads only), go DONE.
  - stall_cycles += 1 each REQ cycle; saturates at all-ones.
- DONE (exactly one cycle): mem_done=1, no request; always returns to IDLE.
  - Upstream advances at the end of DONE, so IDLE never re-accepts the same op.
- HALTED: absorbing until reset. halt_out=1, mem_done=1, mem_stall=0, no requests, all ops ignored.
- mem_stall = op_valid & (state==REQ | (state==IDLE & new op is a memory access) | state==DONE ? 0 : ...):
  - 1 in IDLE when accepting a memory/SC-success op; 1 throughout REQ; 0 in DONE, HALTED, and for non-memory ops.
  - Upstream holds EX/MEM stable while mem_stall=1.
- result_out: for SC, {0..,sc_ok}; otherwise the registered load data. Held until the next op completes.
- Link register:
  - LL sets link_addr=addr, link_valid=1 on its dhit.
  - Cleared by: SC completion (pass or fail); own SW/SC hit whose word matches link_addr; snoop_inv with snoop_addr[31:2]==link_addr[31:2].
  - Snoop and a same-cycle LL dhit to the same word: snoop wins, link_valid=0.
- dhit outside REQ is ignored.

Test Plan:
1. Reset, then LW 0x100 with dhit after 3 cycles returning 0xDEADBEEF:
   - mem_stall high for 4 cycles, then mem_done for 1 cycle; result_out=0xDEADBEEF; stall_cycles=3.
2. SW addr 0x103, data 0x12345678:
   - dmemaddr=0x100, dmemWEN=1 until dhit; dmemREN=0.
3. LL 0x200, then SC 0x200 data 5:
   - SC issues a write; result_out=1; link_valid=0 afterwards.
   - A second SC to 0x200 gives result_out=0 with no dmemWEN.
4. LL 0x200; snoop_inv 0x204 (no clear); snoop_inv 0x200 on the same cycle the SC sits in IDLE:
   - SC fails, result 0, no write.
5. RST asserted during REQ (dmemREN=1):
   - next cycle dmemREN=0, state IDLE, link_valid=0, stall_cycles=0.
6. HALT op:
   - halt_out=1 next cycle and stays 1; a following LW produces no dmemREN.
   - stall_cycles saturation is checked with CNT_W=4: 20 REQ cycles → 15.
